clkdiv_controller: RTL and testbench
====================================

CLKDIV_CONTROLLER -- requirements
Module: clkdiv_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 28: bit width of the divisor and the period counter.
REQ-002 SHALL have parameter DEFAULT_DIVISOR, default 5: divisor loaded at reset.
REQ-003 SHALL have port clock_in  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1: run request; level-sensitive.
REQ-006 SHALL have port cfg_valid  input  1: new divisor offered.
REQ-007 SHALL have port cfg_divisor  input  WIDTH: offered divisor, sampled on handshake.
REQ-008 SHALL have port cfg_ready  output  1: divisor can be accepted this cycle.
REQ-009 SHALL have port clock_out  output  1: divided clock, registered.
REQ-010 SHALL have port tick  output  1: one-cycle pulse marking the first cycle of each output period.
REQ-011 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-012 SHALL have port cfg_error  output  1: one-cycle pulse when an invalid divisor is rejected.

Function
REQ-013 SHALL implement the states IDLE, RUN and DRAIN, with a separate pending_valid flag and pending_divisor register.
REQ-014 SHALL define a transfer as cfg_valid && cfg_ready on a rising edge, with cfg_ready = !pending_valid.
REQ-015 SHALL treat a transferred divisor < 2 as invalid: discard it, pulse cfg_error the next cycle, and leave the active divisor and pending state unchanged.
REQ-016 In IDLE, SHALL load a valid transferred divisor directly into div_active, without setting pending_valid.
REQ-017 In RUN or DRAIN, SHALL store a valid transferred divisor in pending_divisor and set pending_valid.
REQ-018 SHALL keep counter = 0 in IDLE; in RUN/DRAIN, counter increments by 1 and wraps to 0 when counter >= div_active-1.
REQ-019 At each wrap, if pending_valid is set, SHALL copy pending_divisor into div_active and clear pending_valid in the same edge, so the new period starts at counter 0.
REQ-020 SHALL register clock_out = (counter < div_active/2) while in RUN/DRAIN, using integer division and one-cycle latency; in IDLE, clock_out SHALL be 0.
REQ-021 SHALL register tick = 1 for exactly one cycle, following each cycle in RUN/DRAIN where counter == 0.
REQ-022 SHALL transition IDLE -> RUN when enable = 1, with the first counted cycle at counter 0.
REQ-023 SHALL transition RUN -> DRAIN when enable = 0.
REQ-024 SHALL transition DRAIN -> RUN when enable = 1, without any counter disturbance.
REQ-025 SHALL transition DRAIN -> IDLE at wrap; a pending divisor SHALL be applied on that same edge.
REQ-026 SHALL never produce a partial output period due to a reconfiguration; changes take effect only at wrap or in IDLE.
REQ-027 When a transfer and a wrap occur on the same edge, the wrap SHALL use the old pending value (cfg_ready was already low if pending), and the new divisor SHALL become pending.

Reset
REQ-028 On reset_n = 0, SHALL force state = IDLE, counter = 0, div_active = DEFAULT_DIVISOR, pending_valid = 0, clock_out = 0, tick = 0, cfg_error = 0 and busy = 0 (cfg_ready = 1), immediately and without waiting for a clock edge.
REQ-029 SHALL abandon an in-progress period or pending divisor on reset mid-operation; after release, it SHALL restart from IDLE.

Structure
REQ-030 SHALL place the WIDTH default, DEFAULT_DIVISOR, the state encoding (IDLE/RUN/DRAIN) and the minimum-divisor constant 2 in shared package clkdiv_pkg.
REQ-031 SHALL split into one sub-module, clkdiv_counter (counter, wrap detect and clock_out/tick registers), with the FSM and config handshake kept in clkdiv_controller.

Verification
REQ-032 Reset, then enable = 1 with divisor 5 -> clock_out = 1,1,0,0,0 repeating, with tick high in each cycle where clock_out first goes 1.
REQ-033 Divisor 4 offered at counter 1 of a divisor-5 period -> the current period completes 5 cycles, then 1,1,0,0 repeats; cfg_ready is low until that wrap.
REQ-034 Divisor 1 offered in RUN -> cfg_error pulses once, and the divisor-5 pattern continues unchanged.
REQ-035 enable = 0 at counter 2 of divisor 5 -> 2 more cycles run, then busy = 0 and clock_out = 0; re-enable during DRAIN -> no gap in the pattern.
REQ-036 reset_n = 0 mid-period with divisor 7 pending -> outputs 0 at once; after release and enable, the divisor-5 pattern resumes.
REQ-037 Divisor 3 offered in IDLE, then enable -> clock_out = 1,0,0 repeating, starting on the first period.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider: default sizes, minimum legal divisor
// and the controller state encoding.
package clkdiv_pkg;

    localparam int CLKDIV_WIDTH       = 28;
    localparam int CLKDIV_DEFAULT_DIV = 5;
    localparam int CLKDIV_MIN_DIV     = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter for the clock divider: counts 0..div_active-1 while enabled,
// flags the wrap cycle and registers the divided clock and period tick.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = CLKDIV_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             count_en,
    input  logic [WIDTH-1:0] div_active,
    output logic             wrap,
    output logic             clock_out,
    output logic             tick
);

    logic [WIDTH-1:0] counter;

    // ">=" rather than "==" so a shrinking divisor can never strand the counter
    assign wrap = count_en && (counter >= (div_active - WIDTH'(1)));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (!count_en || wrap) begin
            counter <= '0;
        end else begin
            counter <= counter + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            clock_out <= 1'b0;
            tick      <= 1'b0;
        end else begin
            clock_out <= count_en && (counter < (div_active >> 1));
            tick      <= count_en && (counter == '0);
        end
    end

endmodule

// File: rtl/clkdiv_controller.sv
// Programmable clock divider: IDLE/RUN/DRAIN run control plus a one-deep
// divisor handshake whose updates only land at a period boundary or in IDLE.
module clkdiv_controller
    import clkdiv_pkg::*;
#(
    parameter int WIDTH           = CLKDIV_WIDTH,
    parameter int DEFAULT_DIVISOR = CLKDIV_DEFAULT_DIV
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_divisor,
    output logic             cfg_ready,
    output logic             clock_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_error
);

    logic [1:0]       state;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] pending_divisor;
    logic             pending_valid;
    logic             count_en;
    logic             wrap;
    logic             transfer;
    logic             divisor_ok;

    assign count_en   = (state != ST_IDLE);
    assign busy       = count_en;
    assign cfg_ready  = !pending_valid;
    assign transfer   = cfg_valid && cfg_ready;
    assign divisor_ok = (cfg_divisor >= WIDTH'(CLKDIV_MIN_DIV));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (enable) state <= ST_RUN;
                ST_RUN:   if (!enable) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (wrap) begin
                        state <= ST_IDLE;
                    end
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // A transfer only happens while nothing is pending, so the commit of an
    // old pending divisor and the capture of a new one never collide.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            div_active      <= WIDTH'(DEFAULT_DIVISOR);
            pending_divisor <= '0;
            pending_valid   <= 1'b0;
            cfg_error       <= 1'b0;
        end else begin
            cfg_error <= transfer && !divisor_ok;
            if (pending_valid && (wrap || state == ST_IDLE)) begin
                div_active    <= pending_divisor;
                pending_valid <= 1'b0;
            end
            if (transfer && divisor_ok) begin
                if (state == ST_IDLE) begin
                    div_active <= cfg_divisor;
                end else begin
                    pending_divisor <= cfg_divisor;
                    pending_valid   <= 1'b1;
                end
            end
        end
    end

    clkdiv_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .count_en   (count_en),
        .div_active (div_active),
        .wrap       (wrap),
        .clock_out  (clock_out),
        .tick       (tick)
    );

endmodule

// File: tb/tb_clkdiv_controller.sv
// Scoreboard bench for clkdiv_controller: directed per-cycle vectors push the
// expected {clock_out, tick, busy, cfg_ready, cfg_error}; a monitor pops and compares.
module tb_clkdiv_controller;

    localparam int WIDTH = 28;

    logic             clock_in    = 1'b0;
    logic             reset_n     = 1'b0;
    logic             enable      = 1'b0;
    logic             cfg_valid   = 1'b0;
    logic [WIDTH-1:0] cfg_divisor = '0;
    logic             cfg_ready;
    logic             clock_out;
    logic             tick;
    logic             busy;
    logic             cfg_error;

    typedef struct {
        logic [4:0] bits;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    clkdiv_controller #(
        .WIDTH(WIDTH),
        .DEFAULT_DIVISOR(5)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_divisor (cfg_divisor),
        .cfg_ready   (cfg_ready),
        .clock_out   (clock_out),
        .tick        (tick),
        .busy        (busy),
        .cfg_error   (cfg_error)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [4:0] observed();
        return {clock_out, tick, busy, cfg_ready, cfg_error};
    endfunction

    task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got {co,tk,busy,rdy,err}=%b, expected %b", name, act, exp);
        end
    endtask

    // Each call covers one cycle: inputs are set at the falling edge and the
    // expected outputs describe the state right after the following rising edge.
    task automatic applyStimulus(input logic en, input logic cv, input logic [WIDTH-1:0] cd,
                                 input logic [4:0] exp, input string name);
        exp_t e;
        @(negedge clock_in);
        enable      = en;
        cfg_valid   = cv;
        cfg_divisor = cd;
        e.bits = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic runPattern(input int n, input string co_s, input string tk_s, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, '0,
                          {(co_s[i] == "1"), (tk_s[i] == "1"), 1'b1, 1'b1, 1'b0},
                          $sformatf("%s[%0d]", name, i));
        end
    endtask

    always @(posedge clock_in) begin
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e.name, observed(), mon_e.bits);
        end
    end

    initial begin
        $display("[TB] clkdiv_controller bench start");
        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("reset_state", observed(), 5'b00010);
        @(negedge clock_in);
        reset_n = 1'b1;

        // Default divisor 5: 1,1,0,0,0
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "start");
        runPattern(10, "1100011000", "1000010000", "div5");

        // Invalid divisor in RUN is rejected, pattern untouched
        applyStimulus(1'b1, 1'b1, 1, 5'b11111, "bad_div1");
        runPattern(4, "1000", "0000", "after_bad");

        // Divisor 4 offered at counter 1: current period finishes first
        applyStimulus(1'b1, 1'b0, '0, 5'b11110, "b_c0");
        applyStimulus(1'b1, 1'b1, 4,  5'b10100, "b_offer4");
        applyStimulus(1'b1, 1'b0, '0, 5'b00100, "b_c2");
        applyStimulus(1'b1, 1'b0, '0, 5'b00100, "b_c3");
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "b_c4_wrap");
        runPattern(8, "11001100", "10001000", "div4");

        // Divisor 7 pending, then async reset mid-period
        applyStimulus(1'b1, 1'b1, 7,  5'b11100, "e_offer7");
        applyStimulus(1'b1, 1'b0, '0, 5'b10100, "e_c1");
        @(posedge clock_in);
        #3;
        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        #1;
        checkOutput("async_reset", observed(), 5'b00010);
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "restart");
        runPattern(10, "1100011000", "1000010000", "resume5");

        // Disable at counter 2: two more cycles, then IDLE
        applyStimulus(1'b1, 1'b0, '0, 5'b11110, "d_c0");
        applyStimulus(1'b1, 1'b0, '0, 5'b10110, "d_c1");
        applyStimulus(1'b0, 1'b0, '0, 5'b00110, "d_c2_off");
        applyStimulus(1'b0, 1'b0, '0, 5'b00110, "d_c3");
        applyStimulus(1'b0, 1'b0, '0, 5'b00010, "d_c4_idle");
        applyStimulus(1'b0, 1'b0, '0, 5'b00010, "d_idle");

        // Re-enable during DRAIN keeps the pattern continuous
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "d_reen");
        applyStimulus(1'b1, 1'b0, '0, 5'b11110, "d2_c0");
        applyStimulus(1'b1, 1'b0, '0, 5'b10110, "d2_c1");
        applyStimulus(1'b0, 1'b0, '0, 5'b00110, "d2_c2_off");
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "d2_c3_on");
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "d2_c4");
        applyStimulus(1'b1, 1'b0, '0, 5'b11110, "d2_c0b");
        applyStimulus(1'b1, 1'b0, '0, 5'b10110, "d2_c1b");
        applyStimulus(1'b0, 1'b0, '0, 5'b00110, "d2_c2b");
        applyStimulus(1'b0, 1'b0, '0, 5'b00110, "d2_c3b");
        applyStimulus(1'b0, 1'b0, '0, 5'b00010, "d2_idle");

        // IDLE configuration: reject 0, load 3 directly
        applyStimulus(1'b0, 1'b1, 0,  5'b00011, "f_zero");
        applyStimulus(1'b0, 1'b1, 3,  5'b00010, "f_load3");
        applyStimulus(1'b1, 1'b0, '0, 5'b00110, "f_start");
        runPattern(6, "100100", "100100", "div3");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock_in);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
